msk_rnd_source: RTL

//  Fresh-randomness producer for masked gadgets (refresh, DOM/HPC multipliers); drives

---
 rtl/msk_rnd_pkg.sv | 17 +
 rtl/msk_xorshift128_lane.sv | 65 ++++++
 rtl/msk_rnd_source.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/msk_rnd_pkg.sv
// Shared types and constants for the masked-gadget randomness source:
// FSM state encoding, lane geometry and the xorshift128 shift amounts.
package msk_rnd_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, WARM, FILL, RUN} state_e;

  localparam int LANE_W         = 32;
  localparam int BEATS_PER_LANE = 4;
  localparam int SH_A           = 11;
  localparam int SH_B           = 19;
  localparam int SH_C           = 8;

  function automatic int nlane(input int nrnd);
    return (nrnd + LANE_W - 1) / LANE_W;
  endfunction

endpackage

// File: rtl/msk_xorshift128_lane.sv
// One xorshift128 lane: word-addressed seed load, single-step advance, next-w output.
// With MSK_RND_HEALTH_EN the lane also reports an all-zero next state on zero_o.
module msk_xorshift128_lane
  import msk_rnd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_we_i,
  input  logic [1:0]        ld_idx_i,
  input  logic [LANE_W-1:0] ld_data_i,
  input  logic              step_i,
`ifdef MSK_RND_HEALTH_EN
  output logic              zero_o,
`endif
  output logic [LANE_W-1:0] out_o
);

  logic [LANE_W-1:0] x_q, y_q, z_q, w_q;
  logic [LANE_W-1:0] x_d, y_d, z_d, w_d;
  logic [LANE_W-1:0] t, w_nxt;

  assign t     = x_q ^ (x_q << SH_A);
  assign w_nxt = w_q ^ (w_q >> SH_B) ^ t ^ (t >> SH_C);
  assign out_o = w_nxt;

`ifdef MSK_RND_HEALTH_EN
  // Evaluated on the next state so the final seed beat is included.
  assign zero_o = ~|{x_d, y_d, z_d, w_d};
`endif

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    w_d = w_q;
    if (ld_we_i) begin
      case (ld_idx_i)
        2'd0:    x_d = ld_data_i;
        2'd1:    y_d = ld_data_i;
        2'd2:    z_d = ld_data_i;
        default: w_d = ld_data_i;
      endcase
    end else if (step_i) begin
      x_d = y_q;
      y_d = z_q;
      z_d = w_q;
      w_d = w_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      w_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      w_q <= w_d;
    end
  end

endmodule

// File: rtl/msk_rnd_source.sv
// Fresh-randomness source: NLANE seeded xorshift128 lanes behind a registered valid/ready word stream.
// Optional MSK_RND_HEALTH_EN adds health_err (zero-lane seed and frozen-zero output detection).
module msk_rnd_source
  import msk_rnd_pkg::*;
#(
  parameter int NRND   = 64,
  parameter int WARMUP = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            seed_valid,
  output logic            seed_ready,
  input  logic [31:0]     seed_data,
  output logic            rnd_valid,
  input  logic            rnd_ready,
  output logic [NRND-1:0] rnd
`ifdef MSK_RND_HEALTH_EN
  ,output logic           health_err
`endif
);

  // state | meaning
  // IDLE  | waiting for the first seed beat
  // LOAD  | collecting seed beats into the lanes
  // WARM  | discarding WARMUP lane steps
  // FILL  | producing the first word
  // RUN   | one word per handshake; a seed beat restarts loading

  localparam int NLANE  = nlane(NRND);
  localparam int NBEATS = NLANE * BEATS_PER_LANE;
  localparam int BCW    = $clog2(NBEATS);
  localparam int WCW    = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(NBEATS - 1);
  localparam logic [WCW-1:0] WARM_INIT = WCW'(WARMUP);

  state_e                    state_q;
  logic [BCW-1:0]            beat_cnt_q;
  logic [WCW-1:0]            warm_cnt_q;
  logic [NRND-1:0]           rnd_q;
  logic                      rnd_valid_q;
  logic                      seed_ready_q;

  logic                      seed_acc;
  logic                      rnd_hs;
  logic                      step;
  logic [BCW-1:0]            beat_idx;
  logic [NLANE-1:0]          lane_we;
  logic [NLANE*LANE_W-1:0]   lane_cat;

  assign seed_acc = seed_valid & seed_ready_q;
  assign rnd_hs   = rnd_valid_q & rnd_ready;
  // A seed beat in RUN wins over a simultaneous handshake: the word is consumed but lanes do not step.
  assign step     = (state_q == WARM) || (state_q == FILL) ||
                    ((state_q == RUN) && rnd_hs && !seed_acc);

  always_comb begin
    beat_idx = '0;
    if (state_q == LOAD) beat_idx = beat_cnt_q;
  end

`ifdef MSK_RND_HEALTH_EN
  logic [NLANE-1:0] lane_zero;
  logic [1:0]       zrun_q [NLANE];
  logic             word_step;
  logic             word_err;
  logic             health_q;

  assign word_step = (state_q == FILL) || ((state_q == RUN) && rnd_hs && !seed_acc);

  always_comb begin
    word_err = 1'b0;
    for (int l = 0; l < NLANE; l++) begin
      if ((lane_cat[l*LANE_W +: LANE_W] == '0) && (zrun_q[l] == 2'd3)) word_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < NLANE; l++) zrun_q[l] <= '0;
    end else if (seed_acc) begin
      for (int l = 0; l < NLANE; l++) zrun_q[l] <= '0;
    end else if (word_step) begin
      for (int l = 0; l < NLANE; l++) begin
        zrun_q[l] <= (lane_cat[l*LANE_W +: LANE_W] == '0) ? zrun_q[l] + 2'd1 : 2'd0;
      end
    end
  end

  assign health_err = health_q;
`endif

  for (genvar g = 0; g < NLANE; g++) begin : g_lane
    assign lane_we[g] = seed_acc && ((beat_idx >> 2) == BCW'(g));

    msk_xorshift128_lane u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld_we_i   (lane_we[g]),
      .ld_idx_i  (beat_idx[1:0]),
      .ld_data_i (seed_data),
      .step_i    (step),
`ifdef MSK_RND_HEALTH_EN
      .zero_o    (lane_zero[g]),
`endif
      .out_o     (lane_cat[g*LANE_W +: LANE_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      warm_cnt_q   <= '0;
      rnd_q        <= '0;
      rnd_valid_q  <= 1'b0;
      seed_ready_q <= 1'b0;
`ifdef MSK_RND_HEALTH_EN
      health_q     <= 1'b0;
`endif
    end else begin
`ifdef MSK_RND_HEALTH_EN
      if (seed_acc) health_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          seed_ready_q <= 1'b1;
          if (seed_acc) begin
            state_q    <= LOAD;
            beat_cnt_q <= BCW'(1);
          end
        end
        LOAD: begin
          if (seed_acc) begin
            beat_cnt_q <= beat_cnt_q + BCW'(1);
            if (beat_cnt_q == LAST_BEAT) begin
`ifdef MSK_RND_HEALTH_EN
              if (|lane_zero) begin
                state_q  <= IDLE;
                health_q <= 1'b1;
              end else
`endif
              if (WARMUP > 0) begin
                state_q      <= WARM;
                warm_cnt_q   <= WARM_INIT;
                seed_ready_q <= 1'b0;
              end else begin
                state_q      <= FILL;
                seed_ready_q <= 1'b0;
              end
            end
          end
        end
        WARM: begin
          warm_cnt_q <= warm_cnt_q - WCW'(1);
          if (warm_cnt_q == WCW'(1)) state_q <= FILL;
        end
        FILL: begin
          rnd_q        <= lane_cat[NRND-1:0];
          rnd_valid_q  <= 1'b1;
          seed_ready_q <= 1'b1;
          state_q      <= RUN;
`ifdef MSK_RND_HEALTH_EN
          if (word_err) begin
            rnd_valid_q <= 1'b0;
            state_q     <= IDLE;
            health_q    <= 1'b1;
          end
`endif
        end
        RUN: begin
          if (seed_acc) begin
            rnd_valid_q <= 1'b0;
            state_q     <= LOAD;
            beat_cnt_q  <= BCW'(1);
          end else if (rnd_hs) begin
            rnd_q <= lane_cat[NRND-1:0];
`ifdef MSK_RND_HEALTH_EN
            if (word_err) begin
              rnd_valid_q <= 1'b0;
              state_q     <= IDLE;
              health_q    <= 1'b1;
            end
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign seed_ready = seed_ready_q;
  assign rnd_valid  = rnd_valid_q;
  assign rnd        = rnd_q;

endmodule
